// File: rtl/mul_seq.sv
// mul_seq: sequential 32x32 -> 64 multiplier (signed MULT / unsigned MULTU).
// Radix-2 shift-add on operand magnitudes, with the sign applied at the end.
// A start/busy/done handshake matches the sequential divider.
// Latency is a fixed 33 cycles from the start edge to the result.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W    = 1;
  localparam logic [2*WIDTH-1:0] ONE_P    = 1;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mag_a;
  logic [2*WIDTH:0]   p;      // {carry, upper, lower}
  logic               neg;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   p_shift;

  // Unsigned magnitude of an operand; only negative signed values are negated.
  // 0x80000000 maps to 2^31, which fits in the unsigned result.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic                    sgn);
    if (sgn && x[WIDTH-1])
      return ~x + ONE_W;
    return x;
  endfunction

  // Apply the result sign to the magnitude product.
  // A zero magnitude stays zero, so there is no -0 artefact.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] m,
                                                    input logic               n);
    return n ? (~m + ONE_P) : m;
  endfunction

  // One shift-add step: add |A| into the upper half when P[0] is set, then shift right.
  always_comb begin
    sum     = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
    p_shift = {1'b0, p[2*WIDTH:1]};
    if (p[0])
      p_shift = {1'b0, sum, p[WIDTH-1:1]};
  end

  // Datapath registers: operands latched on an accepted start, then iterated during CALC.
  always_ff @(posedge clock) begin
    case (state)
      S_IDLE: begin
        if (start) begin
          mag_a <= magnitude(multiplicand, is_signed);
          p     <= {1'b0, {WIDTH{1'b0}}, magnitude(multiplier, is_signed)};
          neg   <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        end
      end
      S_CALC: p <= p_shift;
      default: ;
    endcase
  end

  // Control FSM and result registers: IDLE -> CALC (WIDTH steps) -> FIX -> IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST)
            state <= S_FIX;
        end
        S_FIX: begin
          {hi, lo} <= apply_sign(p[2*WIDTH-1:0], neg);
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: self-checking bench for mul_seq against an arithmetic reference product.
module tb_mul_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int vectors = 0;
  int miscompares = 0;

  mul_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Reference: full 64-bit product of sign- or zero-extended operands.
  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Drive one start pulse; returns just after the accepting edge N, with inputs scrambled.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clock);
    start = 1'b1; multiplicand = a; multiplier = b; is_signed = s;
    @(posedge clock);
    #1;
    start = 1'b0;
    multiplicand = $urandom;
    multiplier = $urandom;
    is_signed = 1'($urandom_range(0, 1));
  endtask

  // Count edges after N until done; also observes busy and hi/lo hold before done.
  task automatic wait_done(output int cycles, output bit busy_ok, output bit held_ok);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    busy_ok = 1'b1; held_ok = 1'b1; cycles = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        cycles = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (hi !== h0 || lo !== l0) held_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_timing;
    int cyc; bit bok, hok;
    issue(32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start: busy=%b required 1", busy);
    end
    wait_done(cyc, bok, hok);
    vectors++;
    if (cyc != 33 || !bok) begin
      miscompares++;
      $display("FAIL timing_7x-3: done at cycle %0d busy_ok=%0d, required 33 and 1", cyc, bok);
    end
    vectors++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL result_7x-3: hi=%h lo=%h busy=%b, required ffffffff ffffffeb 0", hi, lo, busy);
    end
    @(posedge clock);
    #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_one_cycle: done=%b after N+34, required 0", done);
    end
  endtask

  task automatic test_directed;
    logic [31:0] ta [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                            32'h0000_0000, 32'hDEAD_BEEF, 32'h7FFF_FFFF};
    logic [31:0] tb [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001,
                            32'hDEAD_BEEF, 32'h0000_0000, 32'h8000_0000};
    logic        ts [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [63:0] tx [7] = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001,
                            64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000,
                            64'h0, 64'h0, 64'hC000_0000_8000_0000};
    int cyc; bit bok, hok;
    for (int i = 0; i < 7; i++) begin
      issue(ta[i], tb[i], ts[i]);
      wait_done(cyc, bok, hok);
      vectors++;
      if (cyc != 33 || {hi, lo} !== tx[i]) begin
        miscompares++;
        $display("FAIL directed_%0d: cycle=%0d product=%h, required cycle 33 product %h",
                 i, cyc, {hi, lo}, tx[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b; logic s; logic [63:0] exp_p;
    int cyc; bit bok, hok;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 6 == 1) a = 32'h8000_0000;
      if (i % 6 == 2) b = 32'hFFFF_FFFF;
      if (i % 6 == 3) a = 32'(i);
      s = 1'($urandom_range(0, 1));
      exp_p = ref_product(a, b, s);
      issue(a, b, s);
      wait_done(cyc, bok, hok);
      vectors++;
      if (cyc != 33 || !bok || !hok || {hi, lo} !== exp_p) begin
        miscompares++;
        $display("FAIL random_%0d: a=%h b=%h s=%0d cycle=%0d busy_ok=%0d held=%0d product=%h, required %h",
                 i, a, b, s, cyc, bok, hok, {hi, lo}, exp_p);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int cyc, extra; bit bok, hok;
    issue(32'd12, 32'd12, 1'b0);
    repeat (9) @(posedge clock);
    @(negedge clock);
    start = 1'b1; multiplicand = 32'd5; multiplier = 32'd5; is_signed = 1'b0;
    @(negedge clock);
    start = 1'b0;
    wait_done(cyc, bok, hok);
    vectors++;
    if (cyc != 23 || hi !== 32'd0 || lo !== 32'h90) begin
      miscompares++;
      $display("FAIL busy_ignore: remaining cycles=%0d hi=%h lo=%h, required 23 0 90", cyc, hi, lo);
    end
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (done) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL single_done: %0d extra done pulses, required 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit bok, hok;
    issue(32'd12, 32'd12, 1'b0);
    wait_done(cyc, bok, hok);
    // issue() drives start before edge N+34 of the previous operation
    issue(32'd5, 32'd5, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b after N+34 start, required 1", busy);
    end
    wait_done(cyc, bok, hok);
    vectors++;
    if (cyc != 33 || !hok || hi !== 32'd0 || lo !== 32'd25) begin
      miscompares++;
      $display("FAIL b2b_result: cycle=%0d held=%0d hi=%h lo=%h, required 33 1 0 19", cyc, hok, hi, lo);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, extra; bit bok, hok;
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (15) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    @(negedge clock);
    reset = 1'b0;
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (done || busy) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL reset_abandon: %0d cycles with busy/done after reset, required 0", extra);
    end
    issue(32'd3, 32'd4, 1'b0);
    wait_done(cyc, bok, hok);
    vectors++;
    if (cyc != 33 || hi !== 32'd0 || lo !== 32'd12) begin
      miscompares++;
      $display("FAIL after_reset_3x4: cycle=%0d hi=%h lo=%h, required 33 0 c", cyc, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
